// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// One operation is in flight at a time. ALU inputs are held from registered copies for
// one cycle, or MUL_CYCLES cycles for MUL. The result is then returned as a one-cycle
// pulse to the owning requester.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [4*NUM_REQ-1:0]  req_op,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_result,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_ctrl,
    input  logic [31:0]           alu_result,
    output logic                  busy
);

    localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW  = $clog2(MUL_CYCLES + 1);
    localparam logic [3:0]  OpMul = 4'b0101;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]     owner_q, owner_d;
    logic [3:0]          op_q, op_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [31:0]         resp_result_q, resp_result_d;

    logic                win_found;
    logic [PtrW-1:0]     win_idx;
    logic [3:0]          win_op;
    logic [31:0]         win_a;
    logic [31:0]         win_b;
    int                  off;
    int                  best_off;

    // Round-robin scan: the valid requester with the smallest distance from rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_op    = '0;
        win_a     = '0;
        win_b     = '0;
        off       = 0;
        best_off  = int'(NUM_REQ);
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            off = (j + int'(NUM_REQ) - int'(rr_ptr_q)) % int'(NUM_REQ);
            if (req_valid[j] && (off < best_off)) begin
                best_off  = off;
                win_found = 1'b1;
                win_idx   = PtrW'(j);
                win_op    = req_op[4*j +: 4];
                win_a     = req_a[32*j +: 32];
                win_b     = req_b[32*j +: 32];
            end
        end
    end

    // One-hot grant, only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == StIdle) && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Sequencer next-state: accept in IDLE, count down the hold window in EXEC.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        case (state_q)
            StIdle: begin
                // A grant always pairs with req_valid, so a winner means a transfer.
                if (win_found) begin
                    owner_d = win_idx;
                    op_d    = win_op;
                    a_d     = win_a;
                    b_d     = win_b;
                    cnt_d   = (win_op == OpMul) ? CntW'(MUL_CYCLES) : CntW'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == CntW'(1)) begin
                    resp_result_d         = alu_result;
                    resp_valid_d[owner_q] = 1'b1;
                    rr_ptr_d              = (owner_q == PtrW'(NUM_REQ - 1)) ? '0
                                                                            : owner_q + PtrW'(1);
                    cnt_d                 = '0;
                    state_d               = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
        end
    end

    // ALU operands keep their last latched values; control is forced to 0 outside EXEC.
    always_comb begin
        alu_a       = a_q;
        alu_b       = b_q;
        alu_ctrl    = (state_q == StExec) ? op_q : 4'b0000;
        busy        = (state_q == StExec);
        resp_valid  = resp_valid_q;
        resp_result = resp_result_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a cycle-timeline reference model.
module tb_alu_share_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int MUL_CYCLES = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [4*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_result;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [3:0]            alu_ctrl;
    logic [31:0]           alu_result;
    logic                  busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .busy        (busy)
    );

    // Behavioural ALU: the shared combinational unit outside the arbiter.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'b0001: return a + b;
            4'b0010: return a - b;
            4'b0011: return a & b;
            4'b0100: return a | b;
            4'b0101: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_ctrl, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 2 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input int r, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b);
        req_op[4*r +: 4]  = op;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        int          req;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    // Random-phase requester state and model timeline.
    bit          pend[NUM_REQ];
    logic [3:0]  pop[NUM_REQ];
    logic [31:0] pa[NUM_REQ];
    logic [31:0] pb[NUM_REQ];

    initial begin
        int lat;
        int nbusy;
        bit stable;
        int w;
        logic [NUM_REQ-1:0] seen;
        int ptr;
        int free_at;
        int due;
        int owner;
        logic [31:0] exp_res;
        int win;
        int hold;

        vecs[0] = '{0, 4'b0001, 32'd5,          32'd7,          32'd12,         2};
        vecs[1] = '{1, 4'b0101, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  4};
        vecs[2] = '{2, 4'b1111, 32'h0000_DEAD,  32'h0000_BEEF,  32'h0000_0000,  2};
        vecs[3] = '{0, 4'b0010, 32'd0,          32'd1,          32'hFFFF_FFFF,  2};
        vecs[4] = '{1, 4'b0011, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  2};
        vecs[5] = '{2, 4'b0100, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  2};
        vecs[6] = '{0, 4'b0101, 32'd3,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  4};
        vecs[7] = '{1, 4'b0001, 32'hFFFF_FFFF,  32'd2,          32'd1,          2};

        rst_n     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_alu_ctrl", {28'd0, alu_ctrl}, 0);
        check("reset_resp_valid", {29'd0, resp_valid}, 0);
        check("reset_resp_result", resp_result, 0);
        check("reset_busy", {31'd0, busy}, 0);
        req_valid = '1;
        #1;
        check("reset_req_ready", {29'd0, req_ready}, 0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Directed vectors, one requester at a time.
        for (int v = 0; v < 8; v++) begin
            req_valid = '0;
            req_valid[vecs[v].req] = 1'b1;
            drive_req(vecs[v].req, vecs[v].op, vecs[v].a, vecs[v].b);
            #1;
            check($sformatf("vec%0d_ready", v), {29'd0, req_ready}, 32'd1 << vecs[v].req);
            tick();
            req_valid = '0;
            check($sformatf("vec%0d_busy", v), {31'd0, busy}, 1);
            check($sformatf("vec%0d_alu_ctrl", v), {28'd0, alu_ctrl}, {28'd0, vecs[v].op});
            check($sformatf("vec%0d_alu_a", v), alu_a, vecs[v].a);
            check($sformatf("vec%0d_alu_b", v), alu_b, vecs[v].b);
            lat    = 1;
            nbusy  = 1;
            stable = 1'b1;
            while (resp_valid == '0 && lat < 12) begin
                tick();
                lat++;
                if (busy) begin
                    nbusy++;
                    if (alu_ctrl !== vecs[v].op || alu_a !== vecs[v].a || alu_b !== vecs[v].b)
                        stable = 1'b0;
                end
            end
            check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d_result", v), resp_result, vecs[v].res);
            check($sformatf("vec%0d_resp_valid", v), {29'd0, resp_valid}, 32'd1 << vecs[v].req);
            check($sformatf("vec%0d_busy_cycles", v), nbusy, vecs[v].lat - 1);
            check($sformatf("vec%0d_alu_stable", v), {31'd0, stable}, 1);
            check($sformatf("vec%0d_ctrl_after", v), {28'd0, alu_ctrl}, 0);
            check($sformatf("vec%0d_alu_a_kept", v), alu_a, vecs[v].a);
        end

        // Round-robin with all requesters continuously valid.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) drive_req(i, 4'b0001, 32'(i + 1), 32'd10);
        req_valid = '1;
        #1;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            while (req_ready == '0 && w < 10) begin
                tick();
                w++;
            end
            check($sformatf("rr_grant%0d", g), {29'd0, req_ready}, 32'd1 << (g % NUM_REQ));
            tick();
        end
        req_valid = '0;

        // Back-to-back: requester 1 granted in requester 0's response cycle.
        do_reset();
        drive_req(0, 4'b0001, 32'd5, 32'd7);
        drive_req(1, 4'b0001, 32'd20, 32'd22);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b010;
        #1;
        check("b2b_ready_in_exec", {29'd0, req_ready}, 0);
        tick();
        check("b2b_resp0_valid", {29'd0, resp_valid}, 32'b001);
        check("b2b_resp0_result", resp_result, 32'd12);
        check("b2b_ready1_same_cycle", {29'd0, req_ready}, 32'b010);
        tick();
        req_valid = '0;
        tick();
        check("b2b_resp1_valid", {29'd0, resp_valid}, 32'b010);
        check("b2b_resp1_result", resp_result, 32'd42);

        // Reset in the middle of a MUL from requester 1.
        drive_req(1, 4'b0101, 32'h0000_1234, 32'h0000_0010);
        req_valid = 3'b010;
        #1;
        check("rstmul_ready", {29'd0, req_ready}, 32'b010);
        tick();
        req_valid = '0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmul_alu_a", alu_a, 0);
        check("rstmul_alu_b", alu_b, 0);
        check("rstmul_alu_ctrl", {28'd0, alu_ctrl}, 0);
        check("rstmul_resp_result", resp_result, 0);
        check("rstmul_resp_valid", {29'd0, resp_valid}, 0);
        check("rstmul_busy", {31'd0, busy}, 0);
        req_valid = '1;
        #1;
        check("rstmul_ready_in_reset", {29'd0, req_ready}, 0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        seen  = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | resp_valid;
        end
        check("rstmul_no_resp", {29'd0, seen}, 0);
        for (int i = 0; i < NUM_REQ; i++) drive_req(i, 4'b0001, 32'd1, 32'd1);
        req_valid = '1;
        #1;
        check("rstmul_next_grant", {29'd0, req_ready}, 32'b001);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Randomized traffic against a timeline model.
        do_reset();
        ptr     = 0;
        free_at = 0;
        due     = -1;
        owner   = 0;
        exp_res = '0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            check("rnd_resp_valid", {29'd0, resp_valid},
                  (cyc == due) ? (32'd1 << owner) : 32'd0);
            if (cyc == due) check("rnd_resp_result", resp_result, exp_res);
            check("rnd_busy", {31'd0, busy}, (cyc < free_at) ? 32'd1 : 32'd0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        int r;
                        r = int'($urandom_range(0, 9));
                        if (r < 5)      pop[i] = 4'(r + 1);
                        else if (r < 7) pop[i] = 4'b0101;
                        else            pop[i] = 4'($urandom_range(0, 15));
                        pa[i]   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 9));
                        pb[i]   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 9));
                        pend[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
                req_valid[i] = pend[i];
                drive_req(i, pop[i], pa[i], pb[i]);
            end
            #1;
            win = -1;
            if (cyc >= free_at) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    if (pend[(ptr + k) % NUM_REQ]) win = (ptr + k) % NUM_REQ;
                end
            end
            check("rnd_req_ready", {29'd0, req_ready}, (win >= 0) ? (32'd1 << win) : 32'd0);
            if (win >= 0) begin
                hold    = (pop[win] == 4'b0101) ? MUL_CYCLES : 1;
                free_at = cyc + 1 + hold;
                due     = cyc + 1 + hold;
                owner   = win;
                exp_res = ref_alu(pop[win], pa[win], pb[win]);
                ptr     = (win + 1) % NUM_REQ;
                pend[win] = 1'b0;
            end
            tick();
        end
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
